// File: rtl/gate_pkg.sv
// Shared opcodes and FSM encoding for the gate-unit arbiter and its logic unit.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_logic_unit.sv
// Combinational bitwise logic unit; the reserved opcode yields zero with err set.
module gate_logic_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate_logic_unit between two requesters.
//   state | meaning
//   IDLE  | pick a requester, capture its command on handshake
//   EXEC  | evaluate latched command, register the response
//   RESP  | hold response until the consumer accepts it
module gate_unit_arbiter
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    state_t           r_state;
    logic             r_last_grant;
    logic [2:0]       r_cmd_op;
    logic [WIDTH-1:0] r_cmd_a;
    logic [WIDTH-1:0] r_cmd_b;
    logic             r_cmd_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic             w_idle;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_y;
    logic             w_err;

    // On a tie the requester that was not served last wins; otherwise the lone valid one.
    assign w_grant_id = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_idle     = (r_state == ST_IDLE) & ~rst;
    assign req0_ready = w_idle & req0_valid & ~w_grant_id;
    assign req1_ready = w_idle & req1_valid & w_grant_id;
    assign w_accept   = req0_ready | req1_ready;

    gate_logic_unit #(.WIDTH(WIDTH)) u_logic (
        .op  (r_cmd_op),
        .a   (r_cmd_a),
        .b   (r_cmd_b),
        .y   (w_y),
        .err (w_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cmd_op     <= '0;
            r_cmd_a      <= '0;
            r_cmd_b      <= '0;
            r_cmd_id     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_id <= w_grant_id;
                        r_cmd_op <= w_grant_id ? req1_op : req0_op;
                        r_cmd_a  <= w_grant_id ? req1_a  : req0_a;
                        r_cmd_b  <= w_grant_id ? req1_b  : req0_b;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= w_y;
                    r_rsp_err   <= w_err;
                    r_rsp_id    <= r_cmd_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_last_grant <= r_rsp_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter with hand-computed expected values.
module tb_gate_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    gate_unit_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive one command from requester id, wait for its handshake, check latency and result.
    task automatic issue(input logic id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_y, input logic exp_err,
                         input string tag);
        int   n;
        logic rdy;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        n   = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            step();
            rdy = id ? req1_ready : req0_ready;
            n++;
        end
        check_val({tag, "_hs"}, {31'd0, rdy}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_val({tag, "_t1_valid"}, {31'd0, rsp_valid}, 32'd0);
        step();
        check_val({tag, "_t2_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_val({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_y});
        check_val({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        check_val({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] tt_exp [7];
        int n;
        tt_exp = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};

        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready  = 1'b1;
        step();
        step();
        check_val("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check_val("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_data", {24'd0, rsp_data}, 32'd0);
        check_val("rst_id", {31'd0, rsp_id}, 32'd0);
        check_val("rst_err", {31'd0, rsp_err}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        step();

        // Truth table from requester 0
        for (int op = 0; op < 7; op++)
            issue(1'b0, 3'(op), 8'hF0, 8'hCC, tt_exp[op], 1'b0, $sformatf("tt_op%0d", op));

        // Round-robin starts from a fresh reset so requester 0 wins the first tie
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hFF; req0_b = 8'h0F;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 8'hAA; req1_b = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 20) begin
                step();
                n++;
            end
            check_val($sformatf("rr%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
            check_val($sformatf("rr%0d_id", k), {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check_val($sformatf("rr%0d_data", k), {24'd0, rsp_data},
                      (k % 2 == 0) ? 32'h0F : 32'h55);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Backpressure: hold response 5 cycles while both requesters wait
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check_val("bp_rise", {31'd0, rsp_valid}, 32'd1);
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
        for (int c = 0; c < 5; c++) begin
            step();
            check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("bp_data", {24'd0, rsp_data}, 32'h33);
            check_val("bp_id", {31'd0, rsp_id}, 32'd0);
            check_val("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check_val("bp_ready1", {31'd0, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check_val("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("bp_idle_ready1", {31'd0, req1_ready}, 32'd1);
        check_val("bp_idle_ready0", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Reserved opcode, then a normal one clears err
        issue(1'b1, 3'd7, 8'h12, 8'h34, 8'h00, 1'b1, "rsvd");
        issue(1'b1, 3'd0, 8'h12, 8'h34, 8'h10, 1'b0, "after_rsvd");

        // Reset while in EXEC
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h0F; req1_b = 8'hF0;
        n = 0;
        #1;
        while (!req1_ready && n < 20) begin
            step();
            n++;
        end
        check_val("rx_hs", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rx_valid", {31'd0, rsp_valid}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_val("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_val("rx_grant0", {31'd0, req0_ready}, 32'd1);
        check_val("rx_grant1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Reset while in RESP
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 8'h0F; req1_b = 8'hF0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check_val("rr_resp_rise", {31'd0, rsp_valid}, 32'd1);
        req1_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        check_val("rr_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rr_data", {24'd0, rsp_data}, 32'd0);
        check_val("rr_id", {31'd0, rsp_id}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_val("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_val("rr_grant0", {31'd0, req0_ready}, 32'd1);
        check_val("rr_grant1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Idle stability
        for (int c = 0; c < 10; c++) begin
            step();
            check_val("idle_ready0", {31'd0, req0_ready}, 32'd0);
            check_val("idle_ready1", {31'd0, req1_ready}, 32'd0);
            check_val("idle_valid", {31'd0, rsp_valid}, 32'd0);
        end
        issue(1'b0, 3'd6, 8'h5A, 8'h5A, 8'hFF, 1'b0, "post_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_unit_arbiter.md
Name: gate_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit between two requesters.
- Logic unit ops: AND, OR, NOT-A, NAND, NOR, XOR, XNOR.
- Round-robin arbitration, valid/ready request capture, operation sequencing through a 3-state FSM, result returned on a single tagged response channel.
- Sits between two command sources and the shared gate datapath; this is the only path by which either source reaches that datapath.

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle (when valid).
- req0_op  input  3  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the command.
- rsp_data  output  WIDTH  operation result.
- rsp_err  output  1  opcode was reserved.

Behaviour:
- Opcodes:
  - 0 AND: a&b.
  - 1 OR: a|b.
  - 2 NOTA: ~a (b ignored).
  - 3 NAND: ~(a&b).
  - 4 NOR: ~(a|b).
  - 5 XOR: a^b.
  - 6 XNOR: ~(a^b).
  - 7 reserved: rsp_data=0, rsp_err=1.
- All ops are bitwise over WIDTH bits; no carries, no sign handling.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - Only one requester valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins.
  - reqN_ready=1 only for the granted requester, only in IDLE. Combinational from valid and last_grant.
  - Handshake (valid & ready): latch op, a, b and id into the command register, then go to EXEC.
  - Neither requester valid: stay in IDLE, both readies 0.
- EXEC (1 cycle):
  - Logic unit evaluates the latched command.
  - rsp_data, rsp_err and rsp_id are registered.
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: last_grant <= rsp_id, go to IDLE.
  - Both reqN_ready=0 throughout EXEC and RESP; requesters hold their valid and payload (no drop).
- Latency: acceptance in cycle T, then rsp_valid in cycle T+2.
- Minimum command-to-command spacing: 3 cycles with rsp_ready held high.
- Fairness: under continuous demand from both requesters, grants alternate 0,1,0,1...
- Reset (any state, including mid-operation or mid-response):
  - Next edge forces IDLE, last_grant=1 (requester 0 wins first tie).
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, command register cleared.
  - The in-flight command is discarded with no response.
  - Readies are 0 while rst=1.
- A requester deasserting valid in IDLE before its handshake has no side effect; last_grant is unchanged.
- rsp_ready high while rsp_valid=0 is ignored.

Decomposition:
- Shared package gate_pkg:
  - 3-bit opcode localparams OP_AND..OP_XNOR, OP_RSVD.
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- One natural sub-module: gate_logic_unit.
  - Purely combinational, parameterised by WIDTH.
  - Inputs op, a, b; outputs y, err.
  - Instantiated once inside the arbiter.
- Remaining logic (arbiter, FSM, registers) stays in gate_unit_arbiter.

Test Plan:
- Truth table, WIDTH=8: requester 0 only, a=8'hF0, b=8'hCC, each op 0..6, rsp_ready=1 -> rsp_data = C0, FC, 0F, 3F, 03, 3C, C3; rsp_id=0; rsp_err=0; rsp_valid exactly 2 cycles after each handshake.
- Round-robin: both requesters continuously valid (req0 op=0 a=FF b=0F; req1 op=5 a=AA b=FF) for 4 commands -> rsp_id sequence 0,1,0,1; rsp_data 0F,55,0F,55.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_data and rsp_id stable; both readies 0; on rsp_ready=1, FSM back in IDLE the next cycle.
- Reserved opcode: req1 op=7, a=12, b=34 -> rsp_data=00, rsp_err=1, rsp_id=1; next command op=0 -> rsp_err=0.
- Reset mid-operation: assert rst for 1 cycle while in EXEC, then in RESP on a separate run -> next cycle rsp_valid=0 and FSM in IDLE; no response for the aborted command; with both requesters valid, first grant goes to requester 0.
- Idle stability: no valids for 10 cycles -> readies 0, rsp_valid 0, no state change.
